mem_read_arbiter: RTL and testbench

MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/burst_beat_counter.sv | 47 ++++
 rtl/mem_read_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_read_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state type and default parameters for the memory read arbiter
//
// Purpose : defines the arbiter FSM state enum and the default widths and
//           burst length used by mem_read_arbiter and burst_beat_counter.
// Ports   : none (package).

package mem_arb_pkg;

   localparam int DEF_ADDR_W    = 64;
   localparam int DEF_DATA_W    = 32;
   localparam int DEF_BURST_LEN = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } t_arb_state;

endpackage

// File: rtl/burst_beat_counter.sv
// rtl/burst_beat_counter.sv - beat counter and burst-length check for one refill burst
//
// Purpose : counts accepted beats of the burst in flight (0..BURST_LEN-1) and
//           flags a length error when the last beat lands at the wrong count
//           or a non-last beat lands on the final slot.
// Ports   : clk, arst   - clock, asynchronous active-low reset
//           clear       - hold the count at zero (arbiter idle)
//           beat, last  - an accepted beat and its last flag
//           count       - current beat index
//           err         - single-cycle length-error pulse

module burst_beat_counter
   import mem_arb_pkg::*;
#(
   parameter int BURST_LEN = DEF_BURST_LEN,
   parameter int CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             clear,
   input  logic             beat,
   input  logic             last,
   output logic [CNT_W-1:0] count,
   output logic             err
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(BURST_LEN - 1);

   // An over-long burst wraps to zero rather than saturating, so a run-on
   // burst keeps raising err each time it passes the final slot.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (beat) begin
         if (last || count == MAX_CNT) begin
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

   assign err = beat & (last ? (count != MAX_CNT) : (count == MAX_CNT));

endmodule

// File: rtl/mem_read_arbiter.sv
// rtl/mem_read_arbiter.sv - round-robin arbiter sharing one burst-read memory port between I$ and D$
//
// Purpose : grants the memory read port to the instruction or data cache for
//           one whole refill burst, alternating on contention, and routes the
//           returned beats to the owning cache.
// Ports   : clk, arst                          - clock, asynchronous active-low reset
//           i_instr_req/i_instr_addr           - I$ refill request (level) and line address
//           o_instr_r_valid/_last/_data        - beats toward the I$
//           i_data_req/i_data_addr             - D$ refill request (level) and line address
//           o_data_r_valid/_last/_data         - beats toward the D$
//           o_mem_start_read/o_mem_addr        - burst request and latched address to memory
//           o_mem_r_ready                      - beats accepted
//           i_mem_r_valid/_last/_data          - beats from memory
//           o_busy                             - burst in progress
//           o_burst_err                        - sticky burst-length error

module mem_read_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int BURST_LEN = DEF_BURST_LEN
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              i_instr_req,
   input  logic [ADDR_W-1:0] i_instr_addr,
   output logic              o_instr_r_valid,
   output logic              o_instr_r_last,
   output logic [DATA_W-1:0] o_instr_r_data,
   input  logic              i_data_req,
   input  logic [ADDR_W-1:0] i_data_addr,
   output logic              o_data_r_valid,
   output logic              o_data_r_last,
   output logic [DATA_W-1:0] o_data_r_data,
   output logic              o_mem_start_read,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_r_ready,
   input  logic              i_mem_r_valid,
   input  logic              i_mem_r_last,
   input  logic [DATA_W-1:0] i_mem_r_data,
   output logic              o_busy,
   output logic              o_burst_err
);

   localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   t_arb_state        state_q, state_d;
   logic              last_served_data_q;
   logic [ADDR_W-1:0] addr_q;
   logic              burst_err_q;
   logic              grant_i, grant_d;
   logic              granted;
   logic              beat_err;
   logic [CNT_W-1:0]  beat_count_unused;

   assign granted = (state_q != IDLE);

   // Ties go to whichever cache was not served last. A new grant can only be
   // taken from IDLE, so every burst is followed by at least one IDLE cycle
   // in which the finished requester can drop its level request.
   always_comb begin
      state_d = state_q;
      grant_i = 1'b0;
      grant_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_instr_req && (!i_data_req || last_served_data_q)) begin
               state_d = GRANT_I;
               grant_i = 1'b1;
            end else if (i_data_req) begin
               state_d = GRANT_D;
               grant_d = 1'b1;
            end
         end
         GRANT_I, GRANT_D: begin
            if (i_mem_r_valid && i_mem_r_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q            <= IDLE;
         addr_q             <= '0;
         last_served_data_q <= 1'b1;
         burst_err_q        <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant_i) begin
            addr_q             <= i_instr_addr;
            last_served_data_q <= 1'b0;
         end else if (grant_d) begin
            addr_q             <= i_data_addr;
            last_served_data_q <= 1'b1;
         end
         if (beat_err) begin
            burst_err_q <= 1'b1;
         end
      end
   end

   burst_beat_counter #(
      .BURST_LEN (BURST_LEN),
      .CNT_W     (CNT_W)
   ) u_beat_counter (
      .clk   (clk),
      .arst  (arst),
      .clear (!granted),
      .beat  (i_mem_r_valid & granted),
      .last  (i_mem_r_last),
      .count (beat_count_unused),
      .err   (beat_err)
   );

   assign o_mem_start_read = granted;
   assign o_mem_r_ready    = granted;
   assign o_busy           = granted;
   assign o_mem_addr       = addr_q;
   assign o_burst_err      = burst_err_q;

   assign o_instr_r_valid  = i_mem_r_valid & (state_q == GRANT_I);
   assign o_data_r_valid   = i_mem_r_valid & (state_q == GRANT_D);
   assign o_instr_r_last   = i_mem_r_last & o_instr_r_valid;
   assign o_data_r_last    = i_mem_r_last & o_data_r_valid;

   // Data is shared by both ports during a burst; it is forced to zero while
   // idle so the whole output set is quiet in reset and between bursts.
   assign o_instr_r_data   = granted ? i_mem_r_data : '0;
   assign o_data_r_data    = granted ? i_mem_r_data : '0;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb/tb_mem_read_arbiter.sv - directed scoreboard bench for mem_read_arbiter

module tb_mem_read_arbiter;

   localparam int ADDR_W    = 64;
   localparam int DATA_W    = 32;
   localparam int BURST_LEN = 16;

   logic              clk = 1'b0;
   logic              arst;
   logic              i_instr_req;
   logic [ADDR_W-1:0] i_instr_addr;
   logic              o_instr_r_valid, o_instr_r_last;
   logic [DATA_W-1:0] o_instr_r_data;
   logic              i_data_req;
   logic [ADDR_W-1:0] i_data_addr;
   logic              o_data_r_valid, o_data_r_last;
   logic [DATA_W-1:0] o_data_r_data;
   logic              o_mem_start_read;
   logic [ADDR_W-1:0] o_mem_addr;
   logic              o_mem_r_ready;
   logic              i_mem_r_valid, i_mem_r_last;
   logic [DATA_W-1:0] i_mem_r_data;
   logic              o_busy, o_burst_err;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic              owner_d;
      logic [DATA_W-1:0] data;
      logic              last;
   } t_beat;

   t_beat sb_q[$];

   always #5 clk = ~clk;

   mem_read_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .BURST_LEN (BURST_LEN)
   ) dut (
      .clk              (clk),
      .arst             (arst),
      .i_instr_req      (i_instr_req),
      .i_instr_addr     (i_instr_addr),
      .o_instr_r_valid  (o_instr_r_valid),
      .o_instr_r_last   (o_instr_r_last),
      .o_instr_r_data   (o_instr_r_data),
      .i_data_req       (i_data_req),
      .i_data_addr      (i_data_addr),
      .o_data_r_valid   (o_data_r_valid),
      .o_data_r_last    (o_data_r_last),
      .o_data_r_data    (o_data_r_data),
      .o_mem_start_read (o_mem_start_read),
      .o_mem_addr       (o_mem_addr),
      .o_mem_r_ready    (o_mem_r_ready),
      .i_mem_r_valid    (i_mem_r_valid),
      .i_mem_r_last     (i_mem_r_last),
      .i_mem_r_data     (i_mem_r_data),
      .o_busy           (o_busy),
      .o_burst_err      (o_burst_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      arst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      arst = 1'b1;
   endtask

   // Drive one memory beat for one cycle; route=1 means the bench expects
   // it to appear on the port selected by owner_d.
   task automatic beat(input logic owner_d, input logic [DATA_W-1:0] d,
                       input logic last, input logic route);
      t_beat b;
      i_mem_r_valid = 1'b1;
      i_mem_r_data  = d;
      i_mem_r_last  = last;
      if (route) begin
         b.owner_d = owner_d;
         b.data    = d;
         b.last    = last;
         sb_q.push_back(b);
      end
      tick();
      i_mem_r_valid = 1'b0;
      i_mem_r_last  = 1'b0;
   endtask

   task automatic full_burst(input logic owner_d, input logic [DATA_W-1:0] base);
      for (int i = 0; i < BURST_LEN; i++) begin
         beat(owner_d, base + DATA_W'(i), (i == BURST_LEN - 1), 1'b1);
      end
   endtask

   // Monitor: every routed beat must match the oldest expected beat.
   always @(negedge clk) begin
      if (o_instr_r_valid || o_data_r_valid) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_beat", {62'd0, o_data_r_valid, o_instr_r_valid}, 64'd0);
         end else begin
            t_beat e;
            e = sb_q.pop_front();
            chk("beat_owner_i", {63'd0, o_instr_r_valid}, {63'd0, !e.owner_d});
            chk("beat_owner_d", {63'd0, o_data_r_valid}, {63'd0, e.owner_d});
            chk("beat_data",
                {32'd0, e.owner_d ? o_data_r_data : o_instr_r_data}, {32'd0, e.data});
            chk("beat_last",
                {63'd0, e.owner_d ? o_data_r_last : o_instr_r_last}, {63'd0, e.last});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin
      logic [ADDR_W-1:0] exp_addr;
      logic              exp_d;

      // Reset state with noisy inputs: everything must read zero.
      arst          = 1'b0;
      i_instr_req   = 1'b1;
      i_instr_addr  = 64'hFFFF;
      i_data_req    = 1'b1;
      i_data_addr   = 64'hEEEE;
      i_mem_r_valid = 1'b1;
      i_mem_r_last  = 1'b1;
      i_mem_r_data  = 32'hDEAD_BEEF;
      tick();
      chk("rst_start",  {63'd0, o_mem_start_read}, 64'd0);
      chk("rst_busy",   {63'd0, o_busy}, 64'd0);
      chk("rst_ready",  {63'd0, o_mem_r_ready}, 64'd0);
      chk("rst_addr",   o_mem_addr, 64'd0);
      chk("rst_err",    {63'd0, o_burst_err}, 64'd0);
      chk("rst_valids", {62'd0, o_instr_r_valid, o_data_r_valid}, 64'd0);
      chk("rst_data",   {o_instr_r_data, o_data_r_data}, 64'd0);
      i_instr_req   = 1'b0;
      i_data_req    = 1'b0;
      i_mem_r_valid = 1'b0;
      i_mem_r_last  = 1'b0;
      i_mem_r_data  = '0;
      tick();
      arst = 1'b1;
      tick();

      // Instruction-only 16-beat refill at 0x1000.
      i_instr_req  = 1'b1;
      i_instr_addr = 64'h1000;
      chk("t1_idle_busy", {63'd0, o_busy}, 64'd0);
      tick();
      chk("t1_start", {63'd0, o_mem_start_read}, 64'd1);
      chk("t1_busy",  {63'd0, o_busy}, 64'd1);
      chk("t1_ready", {63'd0, o_mem_r_ready}, 64'd1);
      chk("t1_addr",  o_mem_addr, 64'h1000);
      full_burst(1'b0, 32'hA000_0000);
      i_instr_req = 1'b0;
      chk("t1_done_busy", {63'd0, o_busy}, 64'd0);
      chk("t1_err", {63'd0, o_burst_err}, 64'd0);
      tick();
      chk("t1_stay_idle", {63'd0, o_busy}, 64'd0);

      // Simultaneous requests after reset: I first, one IDLE cycle, then D.
      do_reset();
      i_instr_req  = 1'b1;
      i_instr_addr = 64'h40;
      i_data_req   = 1'b1;
      i_data_addr  = 64'h80;
      tick();
      chk("t2_first_addr", o_mem_addr, 64'h40);
      full_burst(1'b0, 32'hB000_0000);
      i_instr_req = 1'b0;
      chk("t2_gap_busy", {63'd0, o_busy}, 64'd0);
      tick();
      chk("t2_second_busy", {63'd0, o_busy}, 64'd1);
      chk("t2_second_addr", o_mem_addr, 64'h80);
      full_burst(1'b1, 32'hC000_0000);
      i_data_req = 1'b0;
      tick();

      // Continuous contention from reset: order I, D, I.
      do_reset();
      i_instr_req  = 1'b1;
      i_instr_addr = 64'h100;
      i_data_req   = 1'b1;
      i_data_addr  = 64'h200;
      exp_d = 1'b0;
      for (int n = 0; n < 3; n++) begin
         exp_addr = exp_d ? 64'h200 : 64'h100;
         tick();
         chk("t3_grant_addr", o_mem_addr, exp_addr);
         full_burst(exp_d, 32'hE000_0000 + DATA_W'(n * 256));
         chk("t3_gap_busy", {63'd0, o_busy}, 64'd0);
         exp_d = !exp_d;
      end
      i_instr_req = 1'b0;
      i_data_req  = 1'b0;
      tick();

      // Instruction request dropped after beat 3: burst still delivered to I.
      i_instr_req  = 1'b1;
      i_instr_addr = 64'h3000;
      tick();
      chk("t4_addr", o_mem_addr, 64'h3000);
      for (int i = 0; i < BURST_LEN; i++) begin
         if (i == 4) i_instr_req = 1'b0;
         beat(1'b0, 32'h4400_0000 + DATA_W'(i), (i == BURST_LEN - 1), 1'b1);
         if (i == 8) chk("t4_mid_busy", {63'd0, o_busy}, 64'd1);
      end
      chk("t4_done_busy", {63'd0, o_busy}, 64'd0);
      chk("t4_err", {63'd0, o_burst_err}, 64'd0);
      tick();

      // Short burst (last on beat 9): error sets and stays set.
      i_instr_req  = 1'b1;
      i_instr_addr = 64'h5000;
      tick();
      for (int i = 0; i < 10; i++) begin
         beat(1'b0, 32'h5500_0000 + DATA_W'(i), (i == 9), 1'b1);
      end
      i_instr_req = 1'b0;
      chk("t5_done_busy", {63'd0, o_busy}, 64'd0);
      chk("t5_err_set", {63'd0, o_burst_err}, 64'd1);
      tick();
      i_data_req  = 1'b1;
      i_data_addr = 64'h6000;
      tick();
      chk("t5_next_addr", o_mem_addr, 64'h6000);
      full_burst(1'b1, 32'h6600_0000);
      i_data_req = 1'b0;
      chk("t5_err_sticky", {63'd0, o_burst_err}, 64'd1);
      tick();

      // Reset asserted mid data burst, after beat 5.
      i_data_req  = 1'b1;
      i_data_addr = 64'h7000;
      tick();
      chk("t6_addr", o_mem_addr, 64'h7000);
      for (int i = 0; i < 6; i++) begin
         beat(1'b1, 32'h7700_0000 + DATA_W'(i), 1'b0, 1'b1);
      end
      i_mem_r_valid = 1'b1;
      i_mem_r_data  = 32'h7700_0006;
      i_mem_r_last  = 1'b0;
      i_data_req    = 1'b0;
      arst          = 1'b0;
      #1;
      chk("t6_rst_valid", {62'd0, o_instr_r_valid, o_data_r_valid}, 64'd0);
      chk("t6_rst_start", {63'd0, o_mem_start_read}, 64'd0);
      chk("t6_rst_busy",  {62'd0, o_busy, o_mem_r_ready}, 64'd0);
      chk("t6_rst_addr",  o_mem_addr, 64'd0);
      chk("t6_rst_err",   {63'd0, o_burst_err}, 64'd0);
      chk("t6_rst_data",  {o_instr_r_data, o_data_r_data}, 64'd0);
      @(posedge clk);
      #1;
      arst          = 1'b1;
      i_mem_r_valid = 1'b0;
      for (int i = 7; i < BURST_LEN; i++) begin
         beat(1'b1, 32'h7700_0000 + DATA_W'(i), (i == BURST_LEN - 1), 1'b0);
         chk("t6_after_busy", {63'd0, o_busy}, 64'd0);
      end
      chk("t6_after_err", {63'd0, o_burst_err}, 64'd0);
      tick();

      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
